lif_state_update: RTL and testbench

Sequential state-holding end of the LIF neuron datapath. Stores the membrane potential, last-spike flag and refractory count for `N_NEURONS` time-multiplexed neurons. Per timestep it walks the neurons one per cycle:
- drives the decayed potential `beta_u` and `was_spike` to the membrane-potential accumulator;
- captures the accumulator's next potential `u_in`;
- thresholds `u_in` and emits one spike vector per timestep.

---
 rtl/lif_state_update.sv | 124 ++++++++++++
 tb/tb_lif_state_update.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lif_state_update.sv
// Membrane-state store and sequencer for a time-multiplexed LIF neuron array.
// Presents each neuron's decayed potential to the accumulator and thresholds the returned value.
module lif_state_update #(
    parameter int unsigned N_STAGE    = 6,
    parameter int unsigned N_NEURONS  = 4,
    parameter int unsigned BETA_SHIFT = 1,
    parameter int          THRESHOLD  = 32,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned W         = N_STAGE + 2,
    localparam int unsigned IdxW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_valid,
    output logic                 step_ready,
    output logic [IdxW-1:0]      neuron_idx,
    output logic [W-1:0]         beta_u,
    output logic                 was_spike,
    input  logic [W-1:0]         u_in,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 spike_valid
);

    localparam int unsigned RefW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [W-1:0] Thresh   = W'(THRESHOLD);
    localparam logic [RefW-1:0]     RefInit  = RefW'(REFRAC);
    localparam logic [IdxW-1:0]     LastIdx  = IdxW'(N_NEURONS - 1);

    typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q;
    logic signed [W-1:0]    u_q   [N_NEURONS];
    logic [RefW-1:0]        ref_q [N_NEURONS];
    logic [N_NEURONS-1:0]   s_q;
    logic [N_NEURONS-1:0]   vec_q, vec_next;
    logic [N_NEURONS-1:0]   spike_out_q;

    logic signed [W-1:0]    u_cur;
    logic signed [W-1:0]    beta_cur;
    logic                   in_ref;
    logic                   fire;
    logic                   last;

    assign u_cur      = u_q[idx_q];
    assign beta_cur   = u_cur - (u_cur >>> BETA_SHIFT);
    assign beta_u     = beta_cur;
    assign was_spike  = s_q[idx_q];
    assign neuron_idx = idx_q;
    assign spike_out  = spike_out_q;
    assign in_ref     = (ref_q[idx_q] != '0);
    assign fire       = !in_ref && ($signed(u_in) >= Thresh);
    assign last       = (idx_q == LastIdx);

    always_comb begin
        vec_next = vec_q;
        if (state_q == StUpdate && fire) begin
            vec_next[idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_ready  = 1'b0;
        spike_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                step_ready = 1'b1;
                if (step_valid) state_d = StUpdate;
            end
            StUpdate: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                spike_valid = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            s_q         <= '0;
            vec_q       <= '0;
            spike_out_q <= '0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                u_q[i]   <= '0;
                ref_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && step_valid) begin
                idx_q <= '0;
                vec_q <= '0;
            end
            if (state_q == StUpdate) begin
                if (in_ref) begin
                    u_q[idx_q]   <= '0;
                    s_q[idx_q]   <= 1'b0;
                    ref_q[idx_q] <= ref_q[idx_q] - RefW'(1);
                end else if (fire) begin
                    u_q[idx_q]   <= $signed(u_in);
                    s_q[idx_q]   <= 1'b1;
                    ref_q[idx_q] <= RefInit;
                end else begin
                    u_q[idx_q]   <= $signed(u_in);
                    s_q[idx_q]   <= 1'b0;
                end
                vec_q <= vec_next;
                // Publish on the last neuron so spike_out is already valid while spike_valid is high.
                if (last) begin
                    idx_q       <= '0;
                    spike_out_q <= vec_next;
                end else begin
                    idx_q <= idx_q + IdxW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_state_update.sv
// Directed bench for lif_state_update: W=8, 4 neurons, beta=1/2, threshold 32, refractory 2.
module tb_lif_state_update;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_valid;
    logic       step_ready;
    logic [1:0] neuron_idx;
    logic [7:0] beta_u;
    logic       was_spike;
    logic [7:0] u_in;
    logic [3:0] spike_out;
    logic       spike_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lif_state_update #(
        .N_STAGE   (6),
        .N_NEURONS (4),
        .BETA_SHIFT(1),
        .THRESHOLD (32),
        .REFRAC    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .neuron_idx (neuron_idx),
        .beta_u     (beta_u),
        .was_spike  (was_spike),
        .u_in       (u_in),
        .spike_out  (spike_out),
        .spike_valid(spike_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; packed vectors hold neuron i in bits [8i +: 8].
    task automatic do_step(input string tag, input logic [31:0] uins, input logic [31:0] exp_beta,
                           input logic [3:0] exp_ws, input logic [3:0] exp_spk);
        check({tag, " ready"}, 32'(step_ready), 32'd1);
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s idx%0d", tag, i), 32'(neuron_idx), 32'(i));
            check($sformatf("%s beta%0d", tag, i), 32'(beta_u), 32'(exp_beta[i*8 +: 8]));
            check($sformatf("%s ws%0d", tag, i), 32'(was_spike), 32'(exp_ws[i]));
            check($sformatf("%s busy%0d", tag, i), 32'({step_ready, spike_valid}), 32'd0);
            u_in = uins[i*8 +: 8];
            @(negedge clk);
        end
        u_in = 8'd0;
        check({tag, " valid"}, 32'(spike_valid), 32'd1);
        check({tag, " spikes"}, 32'(spike_out), 32'(exp_spk));
        @(negedge clk);
        check({tag, " valid drop"}, 32'(spike_valid), 32'd0);
        check({tag, " ready again"}, 32'(step_ready), 32'd1);
        check({tag, " spikes hold"}, 32'(spike_out), 32'(exp_spk));
    endtask

    initial begin
        int last_c;
        int pulses;

        rst        = 1'b1;
        step_valid = 1'b0;
        u_in       = 8'd0;
        repeat (2) @(negedge clk);
        check("rst ready", 32'(step_ready), 32'd1);
        check("rst idx", 32'(neuron_idx), 32'd0);
        check("rst beta", 32'(beta_u), 32'd0);
        check("rst ws", 32'(was_spike), 32'd0);
        check("rst spikes", 32'(spike_out), 32'd0);
        check("rst valid", 32'(spike_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst ready", 32'(step_ready), 32'd1);

        // Single step, then refractory / negative-decay sequence on stored state.
        do_step("A", {8'd32, 8'd31, 8'd10, 8'd40}, 32'h0, 4'b0000, 4'b1001);
        do_step("B", {8'd0, 8'd0, 8'hF9, 8'd100}, {8'd16, 8'd16, 8'd5, 8'd20}, 4'b1001, 4'b0000);
        do_step("C", {8'd5, 8'd50, 8'd0, 8'd100}, {8'd0, 8'd0, 8'hFD, 8'd0}, 4'b0000, 4'b0100);
        do_step("D", {8'h80, 8'd0, 8'd32, 8'd100}, {8'd0, 8'd25, 8'd0, 8'd0}, 4'b0100, 4'b0011);
        do_step("E", 32'h0, {8'hC0, 8'd0, 8'd16, 8'd50}, 4'b0011, 4'b0000);

        // step_valid held high: one timestep every 6 cycles.
        step_valid = 1'b1;
        last_c     = -1;
        pulses     = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check($sformatf("busy ready c%0d", c), 32'(step_ready), 32'(c % 6 == 0));
            if (spike_valid) begin
                pulses++;
                check($sformatf("busy gap c%0d", c), 32'(c - last_c), 32'd6);
                last_c = c;
            end
        end
        step_valid = 1'b0;
        check("busy pulses", 32'(pulses), 32'd4);

        do_step("F", {4{8'd40}}, 32'h0, 4'b0000, 4'b1111);

        // Abort a timestep at neuron 2; simultaneous step_valid must lose to reset.
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        u_in       = 8'd60;
        repeat (2) @(negedge clk);
        check("abort idx", 32'(neuron_idx), 32'd2);
        rst        = 1'b1;
        step_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        step_valid = 1'b0;
        u_in       = 8'd0;
        check("abort ready", 32'(step_ready), 32'd1);
        check("abort idx0", 32'(neuron_idx), 32'd0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (spike_valid) pulses++;
            @(negedge clk);
        end
        check("abort no valid", 32'(pulses), 32'd0);
        check("abort spikes", 32'(spike_out), 32'd0);

        do_step("H", 32'h0, 32'h0, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
